// File: rtl/sha256_padder_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_padder_if
// Purpose  : Bundles the control, byte-input and block-output handshakes of
//            the SHA-256 message padder.
// Ports    : start/msg_len/busy   - message setup
//            in_data/in_valid/in_ready - byte stream in
//            blk_data/blk_valid/blk_ready/blk_last/blk_total/blk_index
//                                  - padded 512-bit block stream out
//            modport master - the side feeding bytes and consuming blocks
//            modport slave  - the padder itself
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_padder_if #(
    parameter int LEN_W = 32
);
    logic             start;
    logic [LEN_W-1:0] msg_len;
    logic             busy;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [511:0]     blk_data;
    logic             blk_valid;
    logic             blk_ready;
    logic             blk_last;
    logic [63:0]      blk_total;
    logic [63:0]      blk_index;

    modport master (
        output start, msg_len, in_data, in_valid, blk_ready,
        input  busy, in_ready, blk_data, blk_valid, blk_last, blk_total, blk_index
    );

    modport slave (
        input  start, msg_len, in_data, in_valid, blk_ready,
        output busy, in_ready, blk_data, blk_valid, blk_last, blk_total, blk_index
    );
endinterface
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha256_padder
// Purpose  : SHA-256 message front end. Collects a byte stream of a length
//            declared at start, appends the 0x80 marker, zero fill and the
//            64-bit big-endian bit length, and emits 512-bit blocks.
// Ports    : clk - rising-edge clock
//            rst - asynchronous active-high reset
//            bus - sha256_padder_if.slave (setup, byte input, block output)
// Revision : 1.0 - initial release
// ============================================================================
module sha256_padder #(
    parameter int LEN_W = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sha256_padder_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_PAD    = 3'd2,
        S_LENBLK = 3'd3,
        S_EMIT   = 3'd4
    } state_t;

    localparam logic [7:0] C_MARKER   = 8'h80;
    localparam logic [5:0] C_LAST_POS = 6'd55;   // last byte index that still leaves room for the length

    state_t           r_state,      w_state;
    logic [511:0]     r_buf,        w_buf;
    logic [5:0]       r_ptr,        w_ptr;
    logic [LEN_W-1:0] r_rem,        w_rem;
    logic [63:0]      r_bitlen,     w_bitlen;
    logic             r_mark_done,  w_mark_done;
    logic             r_len_pend,   w_len_pend;   // marker placed, length still owed in an extra block
    logic             r_last,       w_last;       // buffered block is the final one
    logic [63:0]      r_blk_total,  w_blk_total;
    logic [63:0]      r_blk_index,  w_blk_index;

    logic [63:0]      w_len64;
    logic [8:0]       w_pos;        // bit offset of byte r_ptr; byte 0 is the MSB

    assign w_len64 = 64'(bus.msg_len);
    assign w_pos   = 9'd504 - {r_ptr, 3'b000};

    always_comb begin
        w_state     = r_state;
        w_buf       = r_buf;
        w_ptr       = r_ptr;
        w_rem       = r_rem;
        w_bitlen    = r_bitlen;
        w_mark_done = r_mark_done;
        w_len_pend  = r_len_pend;
        w_last      = r_last;
        w_blk_total = r_blk_total;
        w_blk_index = r_blk_index;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_rem       = bus.msg_len;
                    w_bitlen    = w_len64 << 3;
                    w_ptr       = '0;
                    w_blk_index = '0;
                    w_buf       = '0;
                    w_mark_done = 1'b0;
                    w_len_pend  = 1'b0;
                    w_last      = 1'b0;
                    w_blk_total = ((w_len64 + 64'd8) >> 6) + 64'd1;
                    w_state     = S_FILL;
                end
            end
            S_FILL: begin
                if (r_rem == '0) begin
                    w_state = S_PAD;
                end else if (bus.in_valid) begin
                    w_buf[w_pos +: 8] = bus.in_data;
                    w_ptr = r_ptr + 6'd1;
                    w_rem = r_rem - LEN_W'(1);
                    // A full block takes priority; the marker then lands in the next block.
                    if (r_ptr == 6'd63) begin
                        w_last  = 1'b0;
                        w_state = S_EMIT;
                    end else if (r_rem == LEN_W'(1)) begin
                        w_state = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (!r_mark_done) begin
                    w_buf[w_pos +: 8] = C_MARKER;
                    w_mark_done = 1'b1;
                end
                if (r_mark_done || (r_ptr <= C_LAST_POS)) begin
                    w_buf[63:0] = r_bitlen;
                    w_last      = 1'b1;
                end else begin
                    w_last      = 1'b0;
                    w_len_pend  = 1'b1;
                end
                w_state = S_EMIT;
            end
            S_LENBLK: begin
                if (!r_mark_done) begin
                    w_buf[511:504] = C_MARKER;
                    w_mark_done    = 1'b1;
                end
                w_buf[63:0] = r_bitlen;
                w_last      = 1'b1;
                w_len_pend  = 1'b0;
                w_state     = S_EMIT;
            end
            S_EMIT: begin
                if (bus.blk_ready) begin
                    w_buf       = '0;
                    w_ptr       = '0;
                    w_blk_index = r_blk_index + 64'd1;
                    if (r_last)
                        w_state = S_IDLE;
                    else if (r_len_pend)
                        w_state = S_LENBLK;
                    else if (r_rem != '0)
                        w_state = S_FILL;
                    else
                        w_state = S_PAD;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_bitlen    <= '0;
            r_mark_done <= 1'b0;
            r_len_pend  <= 1'b0;
            r_last      <= 1'b0;
            r_blk_total <= '0;
            r_blk_index <= '0;
        end else begin
            r_state     <= w_state;
            r_buf       <= w_buf;
            r_ptr       <= w_ptr;
            r_rem       <= w_rem;
            r_bitlen    <= w_bitlen;
            r_mark_done <= w_mark_done;
            r_len_pend  <= w_len_pend;
            r_last      <= w_last;
            r_blk_total <= w_blk_total;
            r_blk_index <= w_blk_index;
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.in_ready  = (r_state == S_FILL) && (r_rem != '0);
    assign bus.blk_valid = (r_state == S_EMIT);
    assign bus.blk_last  = (r_state == S_EMIT) && (r_blk_index == (r_blk_total - 64'd1));
    assign bus.blk_data  = r_buf;
    assign bus.blk_total = r_blk_total;
    assign bus.blk_index = r_blk_index;

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_padder
// Purpose  : Self-checking bench for sha256_padder. Expected blocks come from
//            a byte-queue padding model; a vector table covers the length
//            boundaries, random messages exercise handshakes, and hand-written
//            sequences cover backpressure, ignored start, latency and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_padder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_padder_if #(.LEN_W(32)) bus ();

    sha256_padder #(.LEN_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          len;
        byte unsigned base;
        bit          incr;
        logic [63:0] exp_total;
        logic [63:0] exp_lenf;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic [511:0] obs_first;
    logic [63:0]  obs_total;
    logic [63:0]  obs_lenf;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit bit length.
    function automatic void build_exp(input byte unsigned msg[$], output logic [511:0] blks[$]);
        byte unsigned pad[$];
        logic [63:0]  bl;
        pad = msg;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(8'(bl >> (8 * k)));
        blks.delete();
        for (int b = 0; b < pad.size() / 64; b++) begin
            logic [511:0] v;
            for (int j = 0; j < 64; j++) v[511 - 8*j -: 8] = pad[64*b + j];
            blks.push_back(v);
        end
    endfunction

    task automatic start_msg(input int len);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.msg_len = 32'(len);
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},      bus.busy,      0);
        chk({tag, "_in_ready"},  bus.in_ready,  0);
        chk({tag, "_blk_valid"}, bus.blk_valid, 0);
        chk({tag, "_blk_last"},  bus.blk_last,  0);
        chk({tag, "_blk_data"},  bus.blk_data,  0);
        chk({tag, "_blk_total"}, bus.blk_total, 0);
        chk({tag, "_blk_index"}, bus.blk_index, 0);
    endtask

    task automatic run_msg(input byte unsigned msg[$], input bit rnd);
        logic [511:0] exp_q[$];
        int idx = 0;
        int nb  = 0;
        int cyc = 0;
        build_exp(msg, exp_q);
        start_msg(msg.size());
        while (nb < exp_q.size()) begin
            @(negedge clk);
            bus.in_valid  = (idx < msg.size()) && (!rnd || ($urandom_range(0, 3) != 0));
            bus.in_data   = (idx < msg.size()) ? msg[idx] : 8'h00;
            bus.blk_ready = !rnd || ($urandom_range(0, 2) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.blk_valid && bus.blk_ready) begin
                chk("blk_data",  bus.blk_data,  exp_q[nb]);
                chk("blk_index", bus.blk_index, 64'(nb));
                chk("blk_last",  bus.blk_last,  (nb == exp_q.size() - 1));
                chk("blk_total", bus.blk_total, 64'(exp_q.size()));
                if (nb == 0) obs_first = bus.blk_data;
                obs_total = bus.blk_total;
                obs_lenf  = bus.blk_data[63:0];
                nb++;
            end
            cyc++;
            if (cyc > 3000) begin
                chk("timeout", 1, 0);
                break;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.blk_ready = 1'b0;
        chk("idle_after",     bus.busy, 0);
        chk("bytes_consumed", idx, msg.size());
    endtask

    initial begin
        vec_t         vt[8];
        byte unsigned m[$];
        logic [511:0] eq[$];
        logic [511:0] cap;
        bit           stable;
        int           len;
        int           w;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.msg_len  = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.blk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        vt[0] = '{3,   8'h61, 1'b1, 64'd1, 64'h18};
        vt[1] = '{0,   8'h00, 1'b0, 64'd1, 64'h0};
        vt[2] = '{55,  8'h41, 1'b0, 64'd1, 64'h1B8};
        vt[3] = '{56,  8'h5A, 1'b1, 64'd2, 64'h1C0};
        vt[4] = '{64,  8'h10, 1'b1, 64'd2, 64'h200};
        vt[5] = '{119, 8'hC3, 1'b1, 64'd2, 64'h3B8};
        vt[6] = '{120, 8'h07, 1'b0, 64'd3, 64'h3C0};
        vt[7] = '{128, 8'hF0, 1'b1, 64'd3, 64'h400};

        for (int i = 0; i < 8; i++) begin
            m.delete();
            for (int j = 0; j < vt[i].len; j++)
                m.push_back(vt[i].incr ? 8'(vt[i].base + j) : vt[i].base);
            run_msg(m, (i % 2) == 1);
            chk("tbl_total", obs_total, vt[i].exp_total);
            chk("tbl_lenf",  obs_lenf,  vt[i].exp_lenf);
            if (i == 0) begin
                chk("abc_head", obs_first[511:480], 32'h61626380);
                chk("abc_tail", obs_first[7:0], 8'h18);
            end
        end

        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(0, 200);
            m.delete();
            for (int j = 0; j < len; j++) m.push_back(8'($urandom));
            run_msg(m, 1'b1);
        end

        // Latency, backpressure and ignored start on "abc".
        m = '{8'h61, 8'h62, 8'h63};
        build_exp(m, eq);
        start_msg(3);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = m[k];
            #1;
            chk("fill_ready", bus.in_ready, 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("pad_cycle_no_valid", bus.blk_valid, 0);
        @(negedge clk);
        chk("valid_after_pad", bus.blk_valid, 1);
        cap    = bus.blk_data;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.start   = (k == 3);
            bus.msg_len = 32'd5;
            @(negedge clk);
            if (bus.blk_data !== cap || bus.blk_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.blk_total !== 64'd1 || bus.blk_index !== 64'd0)
                stable = 1'b0;
        end
        bus.start = 1'b0;
        chk("bp_stable", stable, 1);
        chk("bp_data", cap, eq[0]);
        chk("bp_last", bus.blk_last, 1);
        bus.blk_ready = 1'b1;
        @(negedge clk);
        bus.blk_ready = 1'b0;
        chk("bp_done_idle", bus.busy, 0);
        w = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.busy || bus.blk_valid) w++;
        end
        chk("bp_start_ignored", w, 0);

        // Reset in the middle of FILL, then a clean run.
        m.delete();
        for (int j = 0; j < 40; j++) m.push_back(8'($urandom));
        start_msg(40);
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = m[k];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        w = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.busy || bus.blk_valid) w++;
        end
        chk("midrst_no_residual", w, 0);
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 1'b0);
        chk("rst_abc_head", obs_first[511:480], 32'h61626380);
        chk("rst_abc_tail", obs_first[63:0], 64'h18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_padder.md
# sha256_padder

Message front end for the `sha256` core. Accepts a byte stream with a length declared up front and applies FIPS 180-4 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. Emits padded 512-bit blocks over a valid/ready handshake, together with the total block count the core needs before it starts hashing.

## Interface
- `LEN_W`, 32: width of the byte-length input; the maximum message is 2^LEN_W − 1 bytes.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle pulse that latches `msg_len`; honoured only in IDLE.
- `msg_len`  in  LEN_W  message length in bytes.
- `busy`  out  1  high in every state except IDLE.
- `in_data`  in  8  message byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  padder accepts a byte this cycle.
- `blk_data`  out  512  padded block; message byte 0 of the block sits at [511:504].
- `blk_valid`  out  1  `blk_data` is valid.
- `blk_ready`  in  1  downstream consumes the block.
- `blk_last`  out  1  the presented block is the final block.
- `blk_total`  out  64  total number of blocks, equal to ((msg_len + 8) >> 6) + 1; registered at `start`.
- `blk_index`  out  64  zero-based index of the presented block.

## Operation
- State machine states: IDLE, FILL, PAD, LENBLK, EMIT.
- IDLE, `start`=1: latch `rem` = `msg_len`. Set `bitlen` = `msg_len` × 8, zero-extended to 64 bits with wrap on overflow. Clear `ptr`, `blk_index`, the buffer and `mark_done`. Register `blk_total`. Go to FILL.
- FILL:
  - `in_ready` = 1 when `rem` ≠ 0.
  - On each accepted byte: write buffer byte `ptr`, then `ptr`++ and `rem`−−.
  - When `ptr` wraps from 63 to 0, go to EMIT with a non-last block.
  - When `rem` reaches 0 otherwise, go to PAD. With `rem` = 0 on entry (including `msg_len` = 0), go to PAD on the next cycle.
  - When the 64th byte is also the final message byte, go to EMIT; the 0x80 marker goes into the next block.
- PAD (one cycle):
  - If `mark_done` = 0, write 0x80 at byte `ptr` and set `mark_done`.
  - If the marker position is ≤ 55 (or the marker already went into an earlier block): write `bitlen` to bytes 56..63, set last, go to EMIT.
  - Otherwise the remaining bytes are zero: go to EMIT non-last and then to LENBLK.
- LENBLK (one cycle): buffer is already zero; write 0x80 at byte 0 if `mark_done` = 0; write `bitlen` to bytes 56..63; set last; go to EMIT.
- EMIT:
  - `blk_valid` = 1 and `in_ready` = 0. `blk_data` is the buffer, held stable until the transfer.
  - On `blk_valid` & `blk_ready`: clear the buffer and `ptr`, `blk_index`++.
  - If the block was last, go to IDLE.
  - Else if padding is pending (marker placed, no length yet), go to LENBLK.
  - Else if `rem` ≠ 0, go to FILL; else go to PAD.
- `blk_last` = 1 exactly when `blk_index` = `blk_total` − 1 during EMIT.
- `start` while `busy` is ignored.
- Bytes offered while `in_ready` = 0 are not consumed.

## Timing
- Reset values:
  - Outputs `busy`, `in_ready`, `blk_valid`, `blk_last` = 0; `blk_data`, `blk_total`, `blk_index` = 0.
  - Internal: state = IDLE, `ptr` = 0, `rem` = 0.
- Throughput is one byte per cycle in FILL; there is no double buffering, so input stalls during PAD, LENBLK and EMIT.
- Full data block: the 64th byte is accepted at edge N; `blk_valid` is high from the cycle after edge N.
- Final partial block: the last byte is accepted at edge N; PAD is the cycle after edge N; `blk_valid` is high from the cycle after edge N+1.
- LENBLK follows the handshake edge by one cycle; `blk_valid` rises on the next edge.
- `blk_valid` never drops without a transfer except on `rst`.
- `rst` mid-operation: the next cycle shows all reset values, the partial block is discarded, and no residual block is emitted.
- `blk_total` and `blk_index` are stable for the whole time `blk_valid` is high.

## Test plan
- "abc" (`msg_len`=3, bytes 61 62 63) -> one block: `blk_data`[511:480]=32'h61626380, bytes 4..62 are 0, byte 63 = 8'h18; `blk_total`=1, `blk_last`=1.
- `msg_len`=0, `start` only -> one block: byte 0 = 8'h80, all other bytes 0 (length field 0); `blk_total`=1.
- `msg_len`=55 (all 8'h41) -> one block: byte 55 = 8'h80, bytes 56..63 = 64'h1B8; `blk_total`=1.
- `msg_len`=56 -> two blocks:
  - Block 0: byte 56 = 8'h80, bytes 57..63 = 0, `blk_last`=0.
  - Block 1: bytes 0..55 = 0, bytes 56..63 = 64'h1C0, `blk_last`=1.
  - `blk_total`=2.
- `msg_len`=64 -> block 0 is pure data. Block 1: byte 0 = 8'h80, bytes 56..63 = 64'h200.
- Backpressure and reset:
  - Hold `blk_ready`=0 for 10 cycles in EMIT -> `blk_data` stable, `in_ready`=0.
  - Pulse `start` in that window -> no effect.
  - Assert `rst` mid-FILL -> all reset values; a fresh "abc" run afterwards yields the correct block.
